// File: rtl/rf_writeback_queue_if.sv
// ============================================================================
//  Module      : rf_writeback_queue_if
//  Description : Writeback request, register-file write and forwarding bundle.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface rf_writeback_queue_if #(
    parameter int WORD_LEN = 32,
    parameter int PTR_W    = 2
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_reg;
    logic [WORD_LEN-1:0] in_data;
    logic                rf_write_en;
    logic [3:0]          rf_write_reg;
    logic [WORD_LEN-1:0] rf_write_data;
    logic [3:0]          lookup_reg1;
    logic [3:0]          lookup_reg2;
    logic                hit1;
    logic                hit2;
    logic [WORD_LEN-1:0] fwd_data1;
    logic [WORD_LEN-1:0] fwd_data2;
    logic [PTR_W:0]      count;

    modport master (
        output in_valid, in_reg, in_data, lookup_reg1, lookup_reg2,
        input  in_ready, rf_write_en, rf_write_reg, rf_write_data,
        input  hit1, hit2, fwd_data1, fwd_data2, count
    );

    modport slave (
        input  in_valid, in_reg, in_data, lookup_reg1, lookup_reg2,
        output in_ready, rf_write_en, rf_write_reg, rf_write_data,
        output hit1, hit2, fwd_data1, fwd_data2, count
    );
endinterface

`default_nettype wire

// File: rtl/rf_writeback_queue.sv
// ============================================================================
//  Module      : rf_writeback_queue
//  Description : FIFO of pending register writes draining one per cycle into
//                the register file write port, with two forwarding lookups.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module rf_writeback_queue #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    rf_writeback_queue_if.slave wb
);

    localparam logic [PTR_W:0] c_depth_cnt = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [DEPTH-1:0]    valid_q;
    logic [3:0]          ent_reg_q  [DEPTH];
    logic [WORD_LEN-1:0] ent_data_q [DEPTH];
    logic                rf_en_q;
    logic [3:0]          rf_reg_q;
    logic [WORD_LEN-1:0] rf_data_q;

    logic w_ready;
    logic w_enq;
    logic w_drain;

    assign w_ready = !rst && (count_q < c_depth_cnt);
    // Writes to R0 complete the handshake but are never stored.
    assign w_enq   = wb.in_valid && w_ready && (wb.in_reg != 4'd0);
    assign w_drain = (count_q != '0);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_drain) head_d = head_q + 1'b1;
        if (w_enq)   tail_d = tail_q + 1'b1;
        if (w_enq && !w_drain)      count_d = count_q + 1'b1;
        else if (!w_enq && w_drain) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            valid_q   <= '0;
            rf_en_q   <= 1'b0;
            rf_reg_q  <= '0;
            rf_data_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (w_drain) begin
                valid_q[head_q] <= 1'b0;
                rf_en_q         <= 1'b1;
                rf_reg_q        <= ent_reg_q[head_q];
                rf_data_q       <= ent_data_q[head_q];
            end else begin
                rf_en_q <= 1'b0;
            end
            if (w_enq) valid_q[tail_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            ent_reg_q[tail_q]  <= wb.in_reg;
            ent_data_q[tail_q] <= wb.in_data;
        end
    end

    logic [3:0]          w_lk  [2];
    logic                w_hit [2];
    logic [WORD_LEN-1:0] w_fwd [2];

    assign w_lk[0] = wb.lookup_reg1;
    assign w_lk[1] = wb.lookup_reg2;

    // Scan oldest to youngest so the last match is the youngest value.
    for (genvar p = 0; p < 2; p++) begin : g_lookup
        logic [PTR_W-1:0] w_idx;
        always_comb begin
            w_hit[p] = 1'b0;
            w_fwd[p] = '0;
            w_idx    = '0;
            if (w_lk[p] != 4'd0) begin
                if (rf_en_q && (rf_reg_q == w_lk[p])) begin
                    w_hit[p] = 1'b1;
                    w_fwd[p] = rf_data_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    w_idx = head_q + i[PTR_W-1:0];
                    if (valid_q[w_idx] && (ent_reg_q[w_idx] == w_lk[p])) begin
                        w_hit[p] = 1'b1;
                        w_fwd[p] = ent_data_q[w_idx];
                    end
                end
            end
        end
    end

    assign wb.in_ready      = w_ready;
    assign wb.rf_write_en   = rf_en_q;
    assign wb.rf_write_reg  = rf_reg_q;
    assign wb.rf_write_data = rf_data_q;
    assign wb.hit1          = w_hit[0];
    assign wb.hit2          = w_hit[1];
    assign wb.fwd_data1     = w_fwd[0];
    assign wb.fwd_data2     = w_fwd[1];
    assign wb.count         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_queue.sv
// ============================================================================
//  Module      : tb_rf_writeback_queue
//  Description : Directed self-checking bench for rf_writeback_queue.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_queue;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    rf_writeback_queue_if #(.WORD_LEN(32), .PTR_W(2)) wb ();

    rf_writeback_queue #(.WORD_LEN(32), .DEPTH(4), .PTR_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] r, input logic [31:0] d);
        wb.in_valid = v;
        wb.in_reg   = r;
        wb.in_data  = d;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 4'd0, 32'd0);
        wb.lookup_reg1 = 4'd5;
        wb.lookup_reg2 = 4'd0;

        // Reset then idle
        tick();
        tick();
        chk("ready_in_rst", {31'd0, wb.in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", {31'd0, wb.in_ready}, 32'd1);
        chk("rst_count", {29'd0, wb.count}, 32'd0);
        chk("rst_wen", {31'd0, wb.rf_write_en}, 32'd0);
        chk("rst_wreg", {28'd0, wb.rf_write_reg}, 32'd0);
        chk("rst_hit1", {31'd0, wb.hit1}, 32'd0);
        chk("rst_hit2", {31'd0, wb.hit2}, 32'd0);

        // Single write
        drive(1'b1, 4'd5, 32'hDEADBEEF);
        tick();
        drive(1'b0, 4'd0, 32'd0);
        chk("single_count_N", {29'd0, wb.count}, 32'd1);
        chk("single_wen_N", {31'd0, wb.rf_write_en}, 32'd0);
        chk("single_hit_q", {31'd0, wb.hit1}, 32'd1);
        chk("single_fwd_q", wb.fwd_data1, 32'hDEADBEEF);
        tick();
        chk("single_count_N1", {29'd0, wb.count}, 32'd0);
        chk("single_wen_N1", {31'd0, wb.rf_write_en}, 32'd1);
        chk("single_wreg_N1", {28'd0, wb.rf_write_reg}, 32'd5);
        chk("single_wdata_N1", wb.rf_write_data, 32'hDEADBEEF);
        chk("single_hit_out", {31'd0, wb.hit1}, 32'd1);
        tick();
        chk("single_wen_N2", {31'd0, wb.rf_write_en}, 32'd0);
        chk("single_wreg_hold", {28'd0, wb.rf_write_reg}, 32'd5);
        chk("single_hit_gone", {31'd0, wb.hit1}, 32'd0);
        chk("single_fwd_gone", wb.fwd_data1, 32'd0);

        // Back-to-back burst 1..4: drain keeps pace, outputs contiguous
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) begin
                drive(1'b1, k[3:0], k * 32'h100);
                chk("burst_ready", {31'd0, wb.in_ready}, 32'd1);
            end else begin
                drive(1'b0, 4'd0, 32'd0);
            end
            tick();
            chk("burst_count", {29'd0, wb.count}, (k <= 4) ? 32'd1 : 32'd0);
            if (k >= 2) begin
                chk("burst_wen", {31'd0, wb.rf_write_en}, 32'd1);
                chk("burst_wreg", {28'd0, wb.rf_write_reg}, k - 1);
                chk("burst_wdata", wb.rf_write_data, (k - 1) * 32'h100);
            end
        end
        tick();
        chk("burst_wen_end", {31'd0, wb.rf_write_en}, 32'd0);

        // Forward priority: youngest of two writes to R7
        wb.lookup_reg1 = 4'd7;
        wb.lookup_reg2 = 4'd7;
        drive(1'b1, 4'd7, 32'h11);
        tick();
        chk("fwd_first", wb.fwd_data1, 32'h11);
        drive(1'b1, 4'd7, 32'h22);
        tick();
        drive(1'b0, 4'd0, 32'd0);
        chk("fwd_hit1", {31'd0, wb.hit1}, 32'd1);
        chk("fwd_data1", wb.fwd_data1, 32'h22);
        chk("fwd_data2", wb.fwd_data2, 32'h22);
        chk("fwd_out_old", wb.rf_write_data, 32'h11);
        tick();
        chk("fwd_out_young", wb.rf_write_data, 32'h22);
        chk("fwd_hit_outstage", {31'd0, wb.hit1}, 32'd1);
        tick();
        chk("fwd_hit_after", {31'd0, wb.hit1}, 32'd0);
        chk("fwd_data_after", wb.fwd_data1, 32'd0);

        // R0 discard
        wb.lookup_reg2 = 4'd0;
        drive(1'b1, 4'd0, 32'hFFFF);
        #1;
        chk("r0_ready", {31'd0, wb.in_ready}, 32'd1);
        tick();
        drive(1'b0, 4'd0, 32'd0);
        chk("r0_count", {29'd0, wb.count}, 32'd0);
        chk("r0_hit2", {31'd0, wb.hit2}, 32'd0);
        tick();
        chk("r0_wen", {31'd0, wb.rf_write_en}, 32'd0);

        // Reset mid-drain
        wb.lookup_reg1 = 4'd3;
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, k[3:0], 32'hA0 + k);
            tick();
        end
        chk("mid_count_pre", {29'd0, wb.count}, 32'd1);
        chk("mid_wen_pre", {31'd0, wb.rf_write_en}, 32'd1);
        chk("mid_hit_pre", {31'd0, wb.hit1}, 32'd1);
        rst = 1'b1;
        drive(1'b1, 4'd9, 32'h99);
        #1;
        chk("mid_ready_rst", {31'd0, wb.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 4'd0, 32'd0);
        chk("mid_count", {29'd0, wb.count}, 32'd0);
        chk("mid_wen", {31'd0, wb.rf_write_en}, 32'd0);
        chk("mid_wreg", {28'd0, wb.rf_write_reg}, 32'd0);
        chk("mid_hit", {31'd0, wb.hit1}, 32'd0);
        tick();
        chk("mid_wen_after", {31'd0, wb.rf_write_en}, 32'd0);
        tick();
        chk("mid_wen_after2", {31'd0, wb.rf_write_en}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Writer-side companion to the 16 x 32 register file: buffers writeback requests from the pipeline and drains them into the register file's single write port, one per cycle.
- Exposes two forwarding lookup ports so decode can see values that are still queued and not yet committed to the register file.
- Sits between the WB stage and the register file write port (regWrite / writeRegister / writeData).

Parameters:
- WORD_LEN, 32, data width of one register.
- DEPTH, 4, queue entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  writeback request valid.
- in_ready  out  1  queue can accept a request this cycle.
- in_reg  in  4  destination register index.
- in_data  in  WORD_LEN  value to write.
- rf_write_en  out  1  drives register file regWrite; registered.
- rf_write_reg  out  4  drives writeRegister; registered.
- rf_write_data  out  WORD_LEN  drives writeData; registered.
- lookup_reg1, lookup_reg2  in  4  source indices being read by decode.
- hit1, hit2  out  1  a pending write to that index exists (combinational).
- fwd_data1, fwd_data2  out  WORD_LEN  youngest pending value for that index, else 0.
- count  out  PTR_W+1  entries currently queued, excluding the output stage.

Behaviour:
- Reset (rst high at posedge):
  - head = tail = 0 and count = 0.
  - All entry valid bits cleared.
  - rf_write_en, rf_write_reg and rf_write_data all 0.
  - in_ready is forced 0 while rst is high; in_valid is ignored in that cycle.
  - A reset mid-drain discards all queued entries without writing them.
- in_ready = !rst && (count < DEPTH), taken from registered count. There is no bypass when full; a full queue stalls even if it drains in the same cycle.
- Enqueue occurs when in_valid && in_ready at a posedge:
  - in_reg != 0: store at tail, tail = tail+1 mod DEPTH.
  - in_reg == 0: handshake completes, but the request is discarded. tail and count are unchanged. The register file never writes R0.
- Drain occurs at each posedge where count > 0 (pre-edge value):
  - rf_write_en <= 1, rf_write_reg/rf_write_data <= head entry.
  - head = head+1 mod DEPTH.
  - Otherwise rf_write_en <= 0; rf_write_reg/rf_write_data hold their previous values.
- Timing:
  - An entry enqueued at edge N drains at edge N+1.
  - rf_write_en is high for the cycle N+1..N+2, and the register file commits at the negedge inside that cycle.
  - Minimum latency from enqueue to commit is 1.5 cycles; sustained throughput is 1 write per cycle.
- Simultaneous enqueue (nonzero reg) and drain leave count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH. Full vs empty is distinguished by count, not by pointer equality.
- Ordering is strict FIFO. Two queued writes to the same register commit in arrival order.
- Forwarding (per port k, purely combinational):
  - The candidate set is the valid queue entries plus the output stage when rf_write_en = 1. The output stage is oldest; the tail-1 entry is youngest.
  - hitk = 1 iff some candidate has reg == lookup_regk and lookup_regk != 0.
  - fwd_datak = data of the youngest matching candidate, else 0.
  - A request being enqueued in the same cycle is NOT visible; the lookup reflects registered state only.
- count changes only at posedges.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> in_ready=1, count=0, rf_write_en=0 and rf_write_reg=0, hit1=hit2=0.
- Single write: enqueue reg=5, data=0xDEADBEEF at edge N -> count=1 after N; rf_write_en=1, rf_write_reg=5, rf_write_data=0xDEADBEEF after edge N+1; rf_write_en=0 after N+2.
- Fill and stall: hold rf path full by enqueuing reg 1,2,3,4 back-to-back -> in_ready is never deasserted since drain keeps pace. Then check full with DEPTH=4: force 4 entries in consecutive cycles with a burst starting from empty → in_ready stays 1 and the output sequence is 1,2,3,4 in consecutive cycles with no gaps.
- Forward priority: enqueue reg 7 = 0x11, then reg 7 = 0x22, lookup_reg1=7 -> hit1=1, fwd_data1=0x22. After both drain, hit1=0 and fwd_data1=0.
- R0 discard: enqueue reg=0 data=0xFFFF -> handshake completes, count stays 0, rf_write_en never asserts; lookup_reg2=0 gives hit2=0.
- Reset mid-drain: 3 entries queued, assert rst for 1 cycle -> count=0, rf_write_en=0 after the edge, and no further writes are issued.
